pc_gen: RTL and testbench

- Fetch-stage program-counter generator for the pipelined RV32 core.
- Holds the PC register and selects the next PC from these sources: trap vector, execute-stage redirect, stall hold, branch-target-buffer (BTB) prediction, sequential +4.
- Contains a parametrised direct-mapped BTB with 2-bit saturating counters, trained by the execute stage.

---
 rtl/pc_pkg.sv | 29 ++
 rtl/pc_btb.sv | 77 +++++++
 rtl/pc_gen.sv | 80 ++++++++
 tb/tb_pc_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch PC generator and its BTB.
package pc_pkg;

    // Widest PC the BTB entry layout can hold; narrower cores zero-extend.
    localparam int MAX_XLEN = 32;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;  // strongly not-taken
    localparam ctr_t WNT = 2'b01;  // weakly not-taken (reset value)
    localparam ctr_t WT  = 2'b10;  // weakly taken (fresh allocation)
    localparam ctr_t ST  = 2'b11;  // strongly taken

    typedef struct packed {
        logic                valid;
        logic [MAX_XLEN-1:0] tag;
        logic [MAX_XLEN-1:0] target;
        ctr_t                ctr;
    } btb_entry_t;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == ST) ? ST : ctr_t'(c + 2'b01);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == SNT) ? SNT : ctr_t'(c - 2'b01);
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is purely combinational; training writes land on the clock edge, so a
// same-cycle lookup of the index being trained sees the old contents.
module pc_btb
    import pc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    // lookup
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic            taken,
    output logic [XLEN-1:0] target,
    // training
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    btb_entry_t mem [BTB_ENTRIES];

    logic [IDX-1:0]      l_idx, u_idx;
    logic [MAX_XLEN-1:0] l_tag, u_tag;
    btb_entry_t          l_ent, u_ent;
    logic                u_hit;

    // Byte-offset bits never select or tag an entry.
    logic unused_low_bits;
    assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign l_idx = lookup_pc[IDX+1:2];
    assign u_idx = upd_pc[IDX+1:2];
    assign l_tag = MAX_XLEN'(lookup_pc[XLEN-1:IDX+2]);
    assign u_tag = MAX_XLEN'(upd_pc[XLEN-1:IDX+2]);

    // Combinational read of the fetch-side entry.
    always_comb begin
        l_ent  = mem[l_idx];
        hit    = l_ent.valid && (l_ent.tag == l_tag);
        taken  = l_ent.ctr[1];
        target = l_ent.target[XLEN-1:0];
    end

    // Combinational read of the training-side entry.
    always_comb begin
        u_ent = mem[u_idx];
        u_hit = u_ent.valid && (u_ent.tag == u_tag);
    end

    // Table state: async clear, then counter/target training from EX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++)
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    mem[u_idx].ctr    <= sat_inc(u_ent.ctr);
                    mem[u_idx].target <= MAX_XLEN'(upd_target);
                end else begin
                    mem[u_idx].ctr    <= sat_dec(u_ent.ctr);
                end
            end else if (upd_taken) begin
                // Allocation silently evicts whatever alias lived here.
                mem[u_idx] <= '{valid: 1'b1, tag: u_tag,
                                target: MAX_XLEN'(upd_target), ctr: WT};
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: holds pcF and picks the next fetch address
// from trap, EX redirect, stall hold, BTB prediction or pc+4.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 16,
    parameter bit              EN_BTB       = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stallF,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    output logic [XLEN-1:0] pcF,
    output logic [XLEN-1:0] pcPlus4F,
    output logic            predTakenF,
    output logic [XLEN-1:0] predTargetF,
    output logic            misalignF
);

    logic            btb_hit, btb_taken;
    logic [XLEN-1:0] btb_target;
    logic [XLEN-1:0] pc_next;

    generate
        if (EN_BTB) begin : g_btb
            pc_btb #(
                .XLEN        (XLEN),
                .BTB_ENTRIES (BTB_ENTRIES)
            ) u_btb (
                .clk        (clk),
                .reset      (reset),
                .lookup_pc  (pcF),
                .hit        (btb_hit),
                .taken      (btb_taken),
                .target     (btb_target),
                .upd_valid  (upd_valid),
                .upd_pc     (upd_pc),
                .upd_target (upd_target),
                .upd_taken  (upd_taken)
            );
        end else begin : g_no_btb
            // Without a BTB the training port has nothing to drive.
            logic unused_upd;
            assign unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken};
            assign btb_hit    = 1'b0;
            assign btb_taken  = 1'b0;
            assign btb_target = '0;
        end
    endgenerate

    assign pcPlus4F    = pcF + XLEN'(4);  // wraps modulo 2^XLEN
    assign predTakenF  = btb_hit && btb_taken;
    assign predTargetF = predTakenF ? btb_target : '0;
    assign misalignF   = |pcF[1:0];

    // Next-PC select: trap > redirect > stall > prediction > sequential.
    always_comb begin
        pc_next = pcPlus4F;
        if (trap_valid)          pc_next = trap_pc;
        else if (redirect_valid) pc_next = redirect_pc;
        else if (stallF)         pc_next = pcF;
        else if (predTakenF)     pc_next = predTargetF;
    end

    // PC register with asynchronous reset to the boot vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pcF <= RESET_VECTOR;
        else       pcF <= pc_next;
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset/sequencing, stall vs redirect vs trap,
// BTB allocation, counter hysteresis, aliasing, wrap and BTB-disabled build.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallF, trap_valid, redirect_valid, upd_valid, upd_taken;
    logic [31:0] trap_pc, redirect_pc, upd_pc, upd_target;

    logic [31:0] pcF, pcPlus4F, predTargetF;
    logic        predTakenF, misalignF;
    logic [31:0] w_pcF, w_pcPlus4F, w_predTargetF;
    logic        w_predTakenF, w_misalignF;
    logic [31:0] n_pcF, n_pcPlus4F, n_predTargetF;
    logic        n_predTakenF, n_misalignF;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .BTB_ENTRIES(16), .EN_BTB(1'b1)) dut (
        .clk(clk), .reset(reset), .stallF(stallF),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .pcF(pcF), .pcPlus4F(pcPlus4F), .predTakenF(predTakenF),
        .predTargetF(predTargetF), .misalignF(misalignF));

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC), .BTB_ENTRIES(16), .EN_BTB(1'b1)) dut_w (
        .clk(clk), .reset(reset), .stallF(stallF),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .pcF(w_pcF), .pcPlus4F(w_pcPlus4F), .predTakenF(w_predTakenF),
        .predTargetF(w_predTargetF), .misalignF(w_misalignF));

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .BTB_ENTRIES(16), .EN_BTB(1'b0)) dut_n (
        .clk(clk), .reset(reset), .stallF(stallF),
        .trap_valid(trap_valid), .trap_pc(trap_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .pcF(n_pcF), .pcPlus4F(n_pcPlus4F), .predTakenF(n_predTakenF),
        .predTargetF(n_predTargetF), .misalignF(n_misalignF));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of BTB training together with a redirect to go_pc,
    // so the trained entry is looked up right after it is written.
    task automatic upd_go(input logic [31:0] u_pc, input logic [31:0] u_tgt,
                          input logic u_tk, input logic do_upd, input logic [31:0] go_pc);
        upd_valid      = do_upd;
        upd_pc         = u_pc;
        upd_target     = u_tgt;
        upd_taken      = u_tk;
        redirect_valid = 1'b1;
        redirect_pc    = go_pc;
        step();
        upd_valid      = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stallF = 1'b0; trap_valid = 1'b0; redirect_valid = 1'b0;
        upd_valid = 1'b0; upd_taken = 1'b0;
        trap_pc = '0; redirect_pc = '0; upd_pc = '0; upd_target = '0;
        step(); step();

        // Reset state, including the wrapping reset vector build.
        chk("rst_pc", pcF, 32'h0);
        chk("rst_pred", {31'b0, predTakenF}, 32'h0);
        chk("rst_tgt", predTargetF, 32'h0);
        chk("rst_w_pc", w_pcF, 32'hFFFF_FFFC);
        chk("rst_w_plus4", w_pcPlus4F, 32'h0);

        reset = 1'b0;
        chk("first_fetch", pcF, 32'h0);
        step();
        chk("w_second_fetch", w_pcF, 32'h0);
        chk("seq_4", pcF, 32'h4);
        for (int i = 0; i < 15; i++) step();
        chk("seq_40", pcF, 32'h40);

        // Asynchronous reset mid-cycle.
        #3 reset = 1'b1;
        #1 chk("async_rst", pcF, 32'h0);
        step();
        reset = 1'b0;
        chk("rel_0", pcF, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("rel_seq", pcF, 32'(4 * i));
            chk("rel_pred", {31'b0, predTakenF}, 32'h0);
        end
        step();
        chk("seq_10", pcF, 32'h10);

        // Stall holds; redirect and trap override the stall.
        stallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", pcF, 32'h10);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        chk("redir_over_stall", pcF, 32'h200);
        trap_valid = 1'b1; trap_pc = 32'h80;
        step();
        chk("trap_over_redir", pcF, 32'h80);
        trap_valid = 1'b0; redirect_valid = 1'b0; stallF = 1'b0;

        // Allocate 0x24 -> 0x100 and reach it sequentially.
        upd_go(32'h24, 32'h100, 1'b1, 1'b1, 32'h1C);
        chk("alloc_pc1c", pcF, 32'h1C);
        chk("alloc_pred1c", {31'b0, predTakenF}, 32'h0);
        step();
        chk("seq_20", pcF, 32'h20);
        step();
        chk("at_24", pcF, 32'h24);
        chk("pred_24", {31'b0, predTakenF}, 32'h1);
        chk("tgt_24", predTargetF, 32'h100);
        chk("nobtb_pred_24", {31'b0, n_predTakenF}, 32'h0);
        step();
        chk("follow_pred", pcF, 32'h100);
        chk("nobtb_seq", n_pcF, 32'h28);

        // Counter hysteresis: WT -> ST -> WT -> WNT -> SNT, saturated.
        upd_go(32'h24, 32'h100, 1'b1, 1'b1, 32'h24);
        chk("st_pred", {31'b0, predTakenF}, 32'h1);
        upd_go(32'h24, 32'h100, 1'b0, 1'b1, 32'h24);
        chk("wt_pred", {31'b0, predTakenF}, 32'h1);
        chk("wt_tgt", predTargetF, 32'h100);
        upd_go(32'h24, 32'h100, 1'b0, 1'b1, 32'h24);
        chk("wnt_pred", {31'b0, predTakenF}, 32'h0);
        chk("wnt_tgt", predTargetF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            upd_go(32'h24, 32'h100, 1'b0, 1'b1, 32'h24);
            chk("snt_pred", {31'b0, predTakenF}, 32'h0);
        end
        // From SNT one taken only reaches WNT; a second reaches WT with a new target.
        upd_go(32'h24, 32'h100, 1'b1, 1'b1, 32'h24);
        chk("snt_up_pred", {31'b0, predTakenF}, 32'h0);
        upd_go(32'h24, 32'h140, 1'b1, 1'b1, 32'h24);
        chk("wt2_pred", {31'b0, predTakenF}, 32'h1);
        chk("wt2_tgt", predTargetF, 32'h140);
        chk("nobtb_never", {31'b0, n_predTakenF}, 32'h0);

        // Aliasing at index 9: 0x64 misses, then evicts 0x24.
        upd_go(32'h0, 32'h0, 1'b0, 1'b0, 32'h64);
        chk("alias_miss", {31'b0, predTakenF}, 32'h0);
        upd_go(32'h64, 32'h300, 1'b1, 1'b1, 32'h24);
        chk("evicted_24", {31'b0, predTakenF}, 32'h0);
        upd_go(32'h0, 32'h0, 1'b0, 1'b0, 32'h64);
        chk("hit_64", {31'b0, predTakenF}, 32'h1);
        chk("tgt_64", predTargetF, 32'h300);

        // Same-cycle training of the entry being looked up uses old contents.
        upd_valid = 1'b1; upd_pc = 32'h64; upd_target = 32'h300; upd_taken = 1'b0;
        step();
        upd_valid = 1'b0;
        chk("same_cycle_pre", pcF, 32'h300);
        upd_go(32'h0, 32'h0, 1'b0, 1'b0, 32'h64);
        chk("same_cycle_post", {31'b0, predTakenF}, 32'h0);

        // Unmasked misaligned redirect and wrap of pc+4.
        upd_go(32'h0, 32'h0, 1'b0, 1'b0, 32'h102);
        chk("mis_pc", pcF, 32'h102);
        chk("mis_flag", {31'b0, misalignF}, 32'h1);
        step();
        chk("mis_seq", pcF, 32'h106);
        upd_go(32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC);
        chk("wrap_plus4", pcPlus4F, 32'h0);
        chk("wrap_mis", {31'b0, misalignF}, 32'h0);
        step();
        chk("wrap_pc", pcF, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
